// File: rtl/reg_file_sb.sv
// Multi-read-port register file with two write ports, optional write-to-read
// bypass and a per-register busy scoreboard for RAW hazard stalls.
module reg_file_sb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter bit          BYPASS     = 1'b1,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic                           wr0_en,
    input  logic [ADDR_WIDTH-1:0]          wr0_addr,
    input  logic [DATA_WIDTH-1:0]          wr0_data,
    input  logic                           wr1_en,
    input  logic [ADDR_WIDTH-1:0]          wr1_addr,
    input  logic [DATA_WIDTH-1:0]          wr1_data,
    input  logic                           issue_en,
    input  logic [ADDR_WIDTH-1:0]          issue_addr,
    output logic [ADDR_WIDTH:0]            busy_count,
    output logic                           collision_err
);

    localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_nxt;
    logic                  wr0_ok;
    logic                  wr1_ok;
    logic                  issue_ok;
    logic                  set_evt;
    logic                  clr_evt;
    logic                  collide;

    // Qualified enables: register 0 is inert when hardwired to zero
    always_comb begin
        wr0_ok   = wr0_en   && !(ZERO_REG && (wr0_addr   == '0));
        wr1_ok   = wr1_en   && !(ZERO_REG && (wr1_addr   == '0));
        issue_ok = issue_en && !(ZERO_REG && (issue_addr == '0));
    end

    // Scoreboard next state; a same-cycle issue supersedes the completing write
    always_comb begin
        busy_nxt = busy;
        if (wr1_ok) busy_nxt[wr1_addr] = 1'b0;
        if (issue_ok) busy_nxt[issue_addr] = 1'b1;
        set_evt = issue_ok && !busy[issue_addr];
        clr_evt = wr1_ok && busy[wr1_addr] && !(issue_ok && (issue_addr == wr1_addr));
        collide = wr0_ok && wr1_ok && (wr0_addr == wr1_addr);
    end

    // Storage; wr0 is written last so it wins a same-address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr1_ok) regs[wr1_addr] <= wr1_data;
            if (wr0_ok) regs[wr0_addr] <= wr0_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy          <= '0;
            busy_count    <= '0;
            collision_err <= 1'b0;
        end else begin
            busy          <= busy_nxt;
            busy_count    <= busy_count + CNT_W'(set_evt) - CNT_W'(clr_evt);
            collision_err <= collision_err | collide;
        end
    end

    // Read ports: zero register, then wr0 bypass, then wr1 bypass, then storage
    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  bsy;

        assign addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            data = regs[addr];
            bsy  = busy[addr];
            if (BYPASS && wr1_en && (wr1_addr == addr)) begin
                data = wr1_data;
                bsy  = 1'b0;
            end
            if (BYPASS && wr0_en && (wr0_addr == addr)) begin
                data = wr0_data;
            end
            if (ZERO_REG && (addr == '0)) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = data;
        assign rd_busy[k]                          = bsy;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: default build (bypass on, 2 ports) against a
// behavioural array model, plus a 4-port no-bypass build with directed checks.
module tb_reg_file_sb;

    logic clk;
    logic rst_n;

    // Instance A: DATA 32, ADDR 5, NUM_RD 2, BYPASS 1, ZERO_REG 1
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wr0_en, a_wr1_en, a_issue_en;
    logic [4:0]  a_wr0_addr, a_wr1_addr, a_issue_addr;
    logic [31:0] a_wr0_data, a_wr1_data;
    logic [5:0]  a_busy_count;
    logic        a_coll;

    // Instance B: DATA 32, ADDR 4, NUM_RD 4, BYPASS 0, ZERO_REG 1
    logic [15:0]  b_rd_addr;
    logic [127:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic         b_wr0_en, b_wr1_en, b_issue_en;
    logic [3:0]   b_wr0_addr, b_wr1_addr, b_issue_addr;
    logic [31:0]  b_wr0_data, b_wr1_data;
    logic [4:0]   b_busy_count;
    logic         b_coll;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model for instance A
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic        m_coll;

    reg_file_sb u_a (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr0_en(a_wr0_en), .wr0_addr(a_wr0_addr), .wr0_data(a_wr0_data),
        .wr1_en(a_wr1_en), .wr1_addr(a_wr1_addr), .wr1_data(a_wr1_data),
        .issue_en(a_issue_en), .issue_addr(a_issue_addr),
        .busy_count(a_busy_count), .collision_err(a_coll)
    );

    reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_RD(4), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr0_en(b_wr0_en), .wr0_addr(b_wr0_addr), .wr0_data(b_wr0_data),
        .wr1_en(b_wr1_en), .wr1_addr(b_wr1_addr), .wr1_data(b_wr1_data),
        .issue_en(b_issue_en), .issue_addr(b_issue_addr),
        .busy_count(b_busy_count), .collision_err(b_coll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
        m_coll = 1'b0;
    endtask

    // Expected read data from the priority rules: r0, wr0 forward, wr1 forward, stored
    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (a_wr0_en && a_wr0_addr == a) return a_wr0_data;
        if (a_wr1_en && a_wr1_addr == a) return a_wr1_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a_wr1_en && a_wr1_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    // Apply one clock edge's worth of events to the model
    task automatic model_edge();
        if (a_wr0_en && a_wr1_en && a_wr0_addr == a_wr1_addr && a_wr0_addr != 5'd0) m_coll = 1'b1;
        if (a_wr1_en) m_regs[a_wr1_addr] = a_wr1_data;
        if (a_wr0_en) m_regs[a_wr0_addr] = a_wr0_data;
        m_regs[0] = '0;
        if (a_wr1_en) m_busy[a_wr1_addr] = 1'b0;
        if (a_issue_en) m_busy[a_issue_addr] = 1'b1;
        m_busy[0] = 1'b0;
    endtask

    // One cycle on instance A: combinational checks mid-cycle, registered after the edge
    task automatic cyc_a(input string tag);
        #4;
        for (int k = 0; k < 2; k++) begin
            logic [4:0] ad;
            ad = a_rd_addr[k*5 +: 5];
            check($sformatf("%s_rd_data%0d", tag, k), 64'(a_rd_data[k*32 +: 32]), 64'(exp_data(ad)));
            check($sformatf("%s_rd_busy%0d", tag, k), 64'(a_rd_busy[k]), 64'(exp_busy(ad)));
        end
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "_busy_count"}, 64'(a_busy_count), 64'($countones(m_busy)));
        check({tag, "_coll"}, 64'(a_coll), 64'(m_coll));
    endtask

    task automatic idle_a();
        a_wr0_en = 1'b0; a_wr1_en = 1'b0; a_issue_en = 1'b0;
    endtask

    task automatic idle_b();
        b_wr0_en = 1'b0; b_wr1_en = 1'b0; b_issue_en = 1'b0;
    endtask

    logic [31:0] bvals [4];

    initial begin
        rst_n = 1'b0;
        idle_a(); idle_b();
        a_rd_addr = '0; a_wr0_addr = '0; a_wr1_addr = '0; a_issue_addr = '0;
        a_wr0_data = '0; a_wr1_data = '0;
        b_rd_addr = '0; b_wr0_addr = '0; b_wr1_addr = '0; b_issue_addr = '0;
        b_wr0_data = '0; b_wr1_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_busy_count", 64'(a_busy_count), 64'd0);
        check("rst_coll", 64'(a_coll), 64'd0);

        // Write r5 and issue r7, then assert reset mid-cycle with writes pending
        a_wr0_en = 1'b1; a_wr0_addr = 5'd5; a_wr0_data = 32'hDEADBEEF;
        a_issue_en = 1'b1; a_issue_addr = 5'd7;
        a_rd_addr = {5'd7, 5'd5};
        cyc_a("pre_rst");
        check("pre_rst_count", 64'(a_busy_count), 64'd1);
        a_wr0_addr = 5'd6; a_wr0_data = 32'h11111111;
        a_issue_addr = 5'd8;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_r5", 64'(a_rd_data[31:0]), 64'd0);
        check("async_rst_count", 64'(a_busy_count), 64'd0);
        check("async_rst_coll", 64'(a_coll), 64'd0);
        @(posedge clk);
        #1;
        idle_a();
        rst_n = 1'b1;
        a_rd_addr = {5'd5, 5'd6};
        cyc_a("post_rst");

        // Bypass of wr0 into a same-cycle read, and a write to r0
        a_wr0_en = 1'b1; a_wr0_addr = 5'd3; a_wr0_data = 32'h12345678;
        a_rd_addr = {5'd0, 5'd3};
        #1 check("bypass_r3", 64'(a_rd_data[31:0]), 64'h12345678);
        cyc_a("bypass");
        a_wr0_addr = 5'd0; a_wr0_data = 32'hFFFFFFFF;
        cyc_a("wr_r0");
        idle_a();
        cyc_a("rd_r0");
        check("r0_reads_zero", 64'(a_rd_data[63:32]), 64'd0);

        // Scoreboard issue r7, complete via wr1 three cycles later
        a_issue_en = 1'b1; a_issue_addr = 5'd7; a_rd_addr = {5'd3, 5'd7};
        cyc_a("sb_issue");
        idle_a();
        #1 check("sb_busy_r7", 64'(a_rd_busy[0]), 64'd1);
        check("sb_count_1", 64'(a_busy_count), 64'd1);
        cyc_a("sb_wait1");
        cyc_a("sb_wait2");
        a_wr1_en = 1'b1; a_wr1_addr = 5'd7; a_wr1_data = 32'hA5A5A5A5;
        #1 check("sb_wb_busy", 64'(a_rd_busy[0]), 64'd0);
        check("sb_wb_data", 64'(a_rd_data[31:0]), 64'hA5A5A5A5);
        cyc_a("sb_wb");
        check("sb_count_0", 64'(a_busy_count), 64'd0);
        idle_a();

        // Same-cycle issue and clear on busy r9, then duplicate issue
        a_issue_en = 1'b1; a_issue_addr = 5'd9; a_rd_addr = {5'd0, 5'd9};
        cyc_a("r9_issue");
        a_wr1_en = 1'b1; a_wr1_addr = 5'd9; a_wr1_data = 32'h99;
        cyc_a("r9_setclr");
        check("r9_setclr_count", 64'(a_busy_count), 64'd1);
        a_wr1_en = 1'b0;
        cyc_a("r9_dup");
        check("r9_dup_count", 64'(a_busy_count), 64'd1);
        idle_a();
        #1 check("r9_still_busy", 64'(a_rd_busy[0]), 64'd1);

        // Collision on r0 is ignored; collision on r4 stores wr0 data and sticks
        a_wr0_en = 1'b1; a_wr1_en = 1'b1; a_wr0_addr = 5'd0; a_wr1_addr = 5'd0;
        cyc_a("coll_r0");
        check("coll_r0_flag", 64'(a_coll), 64'd0);
        a_wr0_addr = 5'd4; a_wr0_data = 32'd1; a_wr1_addr = 5'd4; a_wr1_data = 32'd2;
        a_rd_addr = {5'd4, 5'd1};
        cyc_a("coll_r4");
        idle_a();
        cyc_a("coll_after");
        check("coll_r4_data", 64'(a_rd_data[63:32]), 64'd1);
        cyc_a("coll_sticky");
        check("coll_sticky_flag", 64'(a_coll), 64'd1);

        // Randomised traffic over a narrow address window to force interactions
        for (int n = 0; n < 300; n++) begin
            a_wr0_en     = 1'($urandom_range(0, 1));
            a_wr1_en     = 1'($urandom_range(0, 1));
            a_issue_en   = 1'($urandom_range(0, 1));
            a_wr0_addr   = 5'($urandom_range(0, 9));
            a_wr1_addr   = 5'($urandom_range(0, 9));
            a_issue_addr = 5'($urandom_range(0, 9));
            a_wr0_data   = $urandom;
            a_wr1_data   = $urandom;
            a_rd_addr    = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 9))};
            cyc_a("rand");
        end
        idle_a();

        // Reset clears the sticky flag
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check("rst_clears_coll", 64'(a_coll), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Instance B: no bypass, four read ports
        for (int k = 0; k < 4; k++) bvals[k] = 32'hC0DE0000 | 32'($urandom_range(0, 16'hFFFF)) | 32'(k << 16);
        for (int k = 0; k < 4; k++) begin
            b_wr0_en = 1'b1; b_wr0_addr = 4'(k + 1); b_wr0_data = bvals[k];
            b_rd_addr = {12'd0, 4'(k + 1)};
            #1 check($sformatf("b_nobypass_r%0d", k + 1), 64'(b_rd_data[31:0]), 64'd0);
            @(posedge clk);
            #1;
        end
        idle_b();
        b_rd_addr = {4'd4, 4'd3, 4'd2, 4'd1};
        #1;
        for (int k = 0; k < 4; k++)
            check($sformatf("b_port%0d", k), 64'(b_rd_data[k*32 +: 32]), 64'(bvals[k]));

        for (int i = 0; i < 16; i++) begin
            b_issue_en = 1'b1; b_issue_addr = 4'(i);
            @(posedge clk);
            #1 check($sformatf("b_count_%0d", i), 64'(b_busy_count), 64'(i));
        end
        b_issue_addr = 4'd5;
        @(posedge clk);
        #1 check("b_count_sat", 64'(b_busy_count), 64'd15);
        idle_b();
        check("b_all_busy", 64'(b_rd_busy), 64'hF);
        b_wr1_en = 1'b1; b_wr1_addr = 4'd1; b_wr1_data = 32'h5555AAAA;
        #1 check("b_wr1_no_force_busy", 64'(b_rd_busy[0]), 64'd1);
        check("b_wr1_no_forward", 64'(b_rd_data[31:0]), 64'(bvals[0]));
        @(posedge clk);
        #1 idle_b();
        check("b_wr1_count", 64'(b_busy_count), 64'd14);
        check("b_wr1_stored", 64'(b_rd_data[31:0]), 64'h5555AAAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-read-port register file with two write ports, write-to-read bypass and a per-register busy scoreboard, for the pipelined MIPS32 core. Port 0 carries single-cycle ALU/load writeback. Port 1 carries late writeback from multi-cycle units such as mult/div. The scoreboard marks a destination busy at issue and clears it at port-1 writeback, so decode can stall on RAW hazards.

## Interface
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, address width; NUM_REGS = 2**ADDR_WIDTH
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data, combinational
- rd_busy  out  NUM_RD  scoreboard bit per read port, combinational
- wr0_en, wr0_addr, wr0_data  in  1, ADDR_WIDTH, DATA_WIDTH  primary write port
- wr1_en, wr1_addr, wr1_data  in  1, ADDR_WIDTH, DATA_WIDTH  late write port; also clears busy
- issue_en, issue_addr  in  1, ADDR_WIDTH  mark destination busy
- busy_count  out  ADDR_WIDTH+1  number of busy registers, registered
- collision_err  out  1  sticky flag, registered

## Operation
- Reset (async, rst_n=0): all registers 0, all busy bits 0, busy_count 0, collision_err 0. Reset asserted mid-operation discards pending writes and issues immediately.
- Writes: registers update at the rising edge when the port enable is high. If ZERO_REG=1, writes to address 0 are ignored.
- Write collision: if wr0_en and wr1_en are both high with equal addresses, wr0 data is stored. collision_err sets next edge and stays 1 until reset. With ZERO_REG=1, a collision on address 0 does not set the flag.
- Read data, per port k:
  - If ZERO_REG=1 and the address is 0: returns 0.
  - Else if BYPASS=1 and wr0 targets the address this cycle: returns wr0_data.
  - Else if BYPASS=1 and wr1 targets the address this cycle: returns wr1_data.
  - Else: returns the stored value.
- Scoreboard:
  - issue_en sets busy[issue_addr] at the next edge.
  - wr1_en clears busy[wr1_addr] at the next edge.
  - Same address, same cycle: set wins, because the new issue supersedes the completing one.
  - wr0 never affects busy. With ZERO_REG=1, busy[0] is always 0.
- rd_busy[k] = busy[rd_addr k].
  - With BYPASS=1, it is forced to 0 when wr1_en targets that address this cycle.
  - A same-cycle issue_en does not affect rd_busy until the next cycle.
- busy_count tracks the number of set busy bits.
  - Updated each edge by +1, -1 or 0 from the net set/clear events.
  - Re-issue of an already-busy register: no increment.
  - Clear of a non-busy register: no decrement.
  - Never exceeds NUM_REGS (minus 1 if ZERO_REG) and never underflows.

## Timing
- Read latency 0: combinational from rd_addr, register state and same-cycle write ports.
- Write latency 1: value is visible on the stored path the cycle after the enable. With BYPASS=1 it is visible in the same cycle.
- Busy set/clear, busy_count and collision_err take effect one edge after the causing inputs.
- No internal stall or handshake. The consumer must hold issue until rd_busy is 0.

## Test plan
- Reset then read: pulse rst_n low asynchronously mid-cycle after writing 0xDEADBEEF to r5 -> rd_data for r5 = 0 immediately; busy_count = 0; collision_err = 0.
- Bypass: wr0 r3 = 0x12345678 with rd_addr0 = 3 in the same cycle -> rd_data0 = 0x12345678 (BYPASS=1), old value with BYPASS=0. Write to r0 -> reads 0.
- Scoreboard: issue r7 -> rd_busy = 1 and busy_count = 1 next cycle. wr1 r7 = 0xA5A5A5A5 three cycles later -> in that cycle rd_busy = 0 with data forwarded; busy_count = 0 after the edge.
- Issue/clear same address and cycle on busy r9 -> r9 stays busy, busy_count unchanged. Duplicate issue of r9 -> count unchanged.
- Collision: wr0 r4 = 1 and wr1 r4 = 2 together -> r4 reads 1 afterwards; collision_err = 1 and stays 1 until reset.
- NUM_RD=4, ADDR_WIDTH=4: four ports read r1..r4 simultaneously with distinct values -> each port returns its own value. Issue all 15 nonzero registers -> busy_count = 15.
